// File: rtl/vball_video_pkg.sv
// Shared constants for the vball raster timing block: default 400x259 timing,
// counter widths and interrupt channel indices.
package vball_video_pkg;

    localparam int VIDEO_HW = 9;
    localparam int VIDEO_VW = 9;

    localparam int H_TOTAL_DEF  = 400;
    localparam int HB_END_DEF   = 2;
    localparam int HB_START_DEF = 242;
    localparam int HS_START_DEF = 288;
    localparam int HS_END_DEF   = 320;
    localparam int V_TOTAL_DEF  = 259;
    localparam int VB_START_DEF = 240;
    localparam int VS_START_DEF = 243;
    localparam int VS_END_DEF   = 253;

    localparam int IRQ_CH_DEF   = 2;
    localparam int IRQ_HPOS_DEF = 0;
    localparam int IRQ_NMI      = 0;
    localparam int IRQ_LINE     = 1;

    // Blanking (active-high) and sync (active-low) outputs, registered together.
    typedef struct packed {
        logic hb;
        logic vb;
        logic hs;
        logic vs;
    } sync_t;

endpackage

// File: rtl/vball_video_timing_if.sv
// Pixel-side bundle of the timing generator: enables, irq programming/ack and
// all raster outputs. master drives the controls, slave is the generator.
interface vball_video_timing_if
    import vball_video_pkg::*;
#(
    parameter int HW     = VIDEO_HW,
    parameter int VW     = VIDEO_VW,
    parameter int IRQ_CH = IRQ_CH_DEF
);
    logic                 ce;
    logic                 flip;
    logic [IRQ_CH*VW-1:0] irq_line;
    logic [IRQ_CH*VW-1:0] irq_mask;
    logic [IRQ_CH-1:0]    irq_ack;
    logic [HW-1:0]        hcount;
    logic [VW-1:0]        vcount;
    logic [HW-1:0]        hpos;
    logic [VW-1:0]        vpos;
    logic                 hb;
    logic                 vb;
    logic                 hs;
    logic                 vs;
    logic [IRQ_CH-1:0]    irq_pulse;
    logic [IRQ_CH-1:0]    irq_pend;
    logic                 frame_start;

    modport master (
        output ce, flip, irq_line, irq_mask, irq_ack,
        input  hcount, vcount, hpos, vpos, hb, vb, hs, vs, irq_pulse, irq_pend, frame_start
    );

    modport slave (
        input  ce, flip, irq_line, irq_mask, irq_ack,
        output hcount, vcount, hpos, vpos, hb, vb, hs, vs, irq_pulse, irq_pend, frame_start
    );
endinterface

// File: rtl/vball_irq_cmp.sv
// One line-compare interrupt channel: masked vcount match strobe plus a sticky
// pending flag cleared by a level ack (a new match beats a same-cycle ack).
module vball_irq_cmp #(
    parameter int VW = 9
) (
    input  logic          clk,
    input  logic          reset_n,
    input  logic          cmp_en,
    input  logic [VW-1:0] v_nxt,
    input  logic [VW-1:0] line,
    input  logic [VW-1:0] mask,
    input  logic          ack,
    output logic          pulse,
    output logic          pend
);
    logic pulse_q, pulse_d;
    logic pend_q, pend_d;

    always_comb begin
        pulse_d = cmp_en && ((v_nxt & mask) == (line & mask));
        pend_d  = pulse_d || (pend_q && !ack);
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            pulse_q <= 1'b0;
            pend_q  <= 1'b0;
        end else begin
            pulse_q <= pulse_d;
            pend_q  <= pend_d;
        end
    end

    assign pulse = pulse_q;
    assign pend  = pend_q;
endmodule

// File: rtl/vball_video_timing.sv
// Raster timing generator: H/V counters, registered blank/sync decode, frame-latched
// flip with mirrored positions, and IRQ_CH line-compare interrupt channels.
module vball_video_timing
    import vball_video_pkg::*;
#(
    parameter int HW       = VIDEO_HW,
    parameter int VW       = VIDEO_VW,
    parameter int H_TOTAL  = H_TOTAL_DEF,
    parameter int HB_END   = HB_END_DEF,
    parameter int HB_START = HB_START_DEF,
    parameter int HS_START = HS_START_DEF,
    parameter int HS_END   = HS_END_DEF,
    parameter int V_TOTAL  = V_TOTAL_DEF,
    parameter int VB_START = VB_START_DEF,
    parameter int VS_START = VS_START_DEF,
    parameter int VS_END   = VS_END_DEF,
    parameter int IRQ_CH   = IRQ_CH_DEF,
    parameter int IRQ_HPOS = IRQ_HPOS_DEF
) (
    input logic                 clk,
    input logic                 reset_n,
    vball_video_timing_if.slave vid
);
    if (H_TOTAL > (1 << HW) || V_TOTAL > (1 << VW) || HB_END >= HB_START ||
        HS_START >= HS_END || VS_START >= VS_END) begin : g_bad_timing
        $error("vball_video_timing: inconsistent timing parameters");
    end

    localparam logic [HW-1:0] H_LAST     = HW'(H_TOTAL - 1);
    localparam logic [VW-1:0] V_LAST     = VW'(V_TOTAL - 1);
    localparam logic [HW-1:0] HB_END_C   = HW'(HB_END);
    localparam logic [HW-1:0] HB_START_C = HW'(HB_START);
    localparam logic [HW-1:0] HS_START_C = HW'(HS_START);
    localparam logic [HW-1:0] HS_END_C   = HW'(HS_END);
    localparam logic [VW-1:0] VB_START_C = VW'(VB_START);
    localparam logic [VW-1:0] VS_START_C = VW'(VS_START);
    localparam logic [VW-1:0] VS_END_C   = VW'(VS_END);
    localparam logic [HW-1:0] IRQ_HPOS_C = HW'(IRQ_HPOS);
    // Mirror axes: flipped positions map the active window onto itself.
    localparam logic [HW-1:0] H_FLIP     = HW'(HB_START + HB_END - 1);
    localparam logic [VW-1:0] V_FLIP     = VW'(VB_START - 1);
    localparam sync_t         SYNC_RST   = '{hb: 1'b1, vb: 1'b0, hs: 1'b1, vs: 1'b1};

    logic [HW-1:0] hcount_q, hcount_d, hpos_q, hpos_d, h_nxt;
    logic [VW-1:0] vcount_q, vcount_d, vpos_q, vpos_d, v_nxt;
    sync_t         sync_q, sync_d;
    logic          flip_q, flip_d;
    logic          frame_start_q, frame_start_d;
    logic          wrap, cmp_en;
    logic [IRQ_CH-1:0] irq_pulse, irq_pend;

    always_comb begin
        h_nxt = (hcount_q == H_LAST) ? '0 : hcount_q + HW'(1);
        v_nxt = vcount_q;
        if (hcount_q == H_LAST) begin
            v_nxt = (vcount_q == V_LAST) ? '0 : vcount_q + VW'(1);
        end
        wrap   = (h_nxt == '0) && (v_nxt == '0);
        cmp_en = vid.ce && (h_nxt == IRQ_HPOS_C);
    end

    // Outputs are decoded from the next count so they line up with hcount/vcount.
    always_comb begin
        // NOTE: every _d gets its hold value first, so the ce=0 path cannot infer a latch.
        hcount_d      = hcount_q;
        vcount_d      = vcount_q;
        hpos_d        = hpos_q;
        vpos_d        = vpos_q;
        sync_d        = sync_q;
        flip_d        = flip_q;
        frame_start_d = 1'b0;
        if (vid.ce) begin
            hcount_d      = h_nxt;
            vcount_d      = v_nxt;
            sync_d.hb     = (h_nxt < HB_END_C) || (h_nxt >= HB_START_C);
            sync_d.vb     = (v_nxt >= VB_START_C);
            sync_d.hs     = !((h_nxt >= HS_START_C) && (h_nxt < HS_END_C));
            sync_d.vs     = !((v_nxt >= VS_START_C) && (v_nxt < VS_END_C));
            frame_start_d = wrap;
            if (wrap) begin
                flip_d = vid.flip;
            end
            hpos_d = flip_d ? H_FLIP - h_nxt : h_nxt;
            vpos_d = flip_d ? V_FLIP - v_nxt : v_nxt;
        end
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            hcount_q      <= '0;
            vcount_q      <= '0;
            hpos_q        <= H_FLIP;
            vpos_q        <= V_FLIP;
            sync_q        <= SYNC_RST;
            flip_q        <= 1'b0;
            frame_start_q <= 1'b0;
        end else begin
            // NOTE: non-blocking so every register samples pre-edge values of the others.
            hcount_q      <= hcount_d;
            vcount_q      <= vcount_d;
            hpos_q        <= hpos_d;
            vpos_q        <= vpos_d;
            sync_q        <= sync_d;
            flip_q        <= flip_d;
            frame_start_q <= frame_start_d;
        end
    end

    for (genvar k = 0; k < IRQ_CH; k++) begin : g_irq
        vball_irq_cmp #(.VW(VW)) u_cmp (
            .clk    (clk),
            .reset_n(reset_n),
            .cmp_en (cmp_en),
            .v_nxt  (v_nxt),
            .line   (vid.irq_line[k*VW +: VW]),
            .mask   (vid.irq_mask[k*VW +: VW]),
            .ack    (vid.irq_ack[k]),
            .pulse  (irq_pulse[k]),
            .pend   (irq_pend[k])
        );
    end

    assign vid.hcount      = hcount_q;
    assign vid.vcount      = vcount_q;
    assign vid.hpos        = hpos_q;
    assign vid.vpos        = vpos_q;
    assign vid.hb          = sync_q.hb;
    assign vid.vb          = sync_q.vb;
    assign vid.hs          = sync_q.hs;
    assign vid.vs          = sync_q.vs;
    assign vid.irq_pulse   = irq_pulse;
    assign vid.irq_pend    = irq_pend;
    assign vid.frame_start = frame_start_q;
endmodule
